// File: rtl/plcp_receiver.sv
// 802.11a PLCP receive deframer: preamble hunt, SIGNAL decode (PLCP_RECEIVER_PARITY_CHECK_EN adds parity/reserved/tail checks), LENGTH-octet payload forward.
// Latency: all outputs registered, one cycle after the sampled input bit.
// Backpressure: none; consumes one bit per InputValid cycle, downstream must take one bit per cycle.
module plcp_receiver #(
    parameter int PREAMBLE_BITS = 96
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Input,
    input  logic        InputValid,
    output logic        Output,
    output logic        OutputValid,
    output logic [3:0]  Rate,
    output logic [11:0] Length,
    output logic        SignalValid,
    output logic        SignalError,
    output logic        FrameDone,
    output logic        Busy
);

    typedef enum logic [1:0] {HUNT, PREAMBLE, SIGNAL, DATA} state_t;

    state_t      state, state_nx;
    logic [6:0]  pre_cnt, pre_cnt_nx;
    logic        pre_exp, pre_exp_nx;
    logic [4:0]  sig_cnt, sig_cnt_nx;
    logic [22:0] sig_sr, sig_sr_nx;
    logic [14:0] data_cnt, data_cnt_nx;
    logic        out_nx, out_vld_nx, sv_nx, se_nx, fd_nx;
    logic [3:0]  rate_nx;
    logic [11:0] len_nx;
    logic        sig_ok;

    // At the 24th bit, bit k of SIGNAL sits in sig_sr[k] and bit 23 is on Input.
    always_comb begin
        sig_ok = sig_sr[3];
`ifdef PLCP_RECEIVER_PARITY_CHECK_EN
        sig_ok = sig_ok && (sig_sr[17] == ^sig_sr[16:0]) && !sig_sr[4]
                 && (sig_sr[22:18] == 5'd0) && !Input;
`endif
    end

    always_comb begin
        state_nx    = state;
        pre_cnt_nx  = pre_cnt;
        pre_exp_nx  = pre_exp;
        sig_cnt_nx  = sig_cnt;
        sig_sr_nx   = sig_sr;
        data_cnt_nx = data_cnt;
        out_nx      = Output;
        out_vld_nx  = 1'b0;
        rate_nx     = Rate;
        len_nx      = Length;
        sv_nx       = 1'b0;
        se_nx       = 1'b0;
        fd_nx       = 1'b0;
        if (InputValid) begin
            case (state)
                HUNT: begin
                    if (Input) begin
                        state_nx   = PREAMBLE;
                        pre_cnt_nx = 7'd1;
                        pre_exp_nx = 1'b0;
                    end
                end
                PREAMBLE: begin
                    if (Input == pre_exp) begin
                        pre_cnt_nx = pre_cnt + 7'd1;
                        pre_exp_nx = !pre_exp;
                        if (pre_cnt_nx == 7'(PREAMBLE_BITS)) begin
                            state_nx   = SIGNAL;
                            pre_cnt_nx = 7'd0;
                            sig_cnt_nx = 5'd0;
                        end
                    end else if (Input) begin
                        // A stray 1 may itself be the start of a real preamble.
                        pre_cnt_nx = 7'd1;
                        pre_exp_nx = 1'b0;
                    end else begin
                        state_nx   = HUNT;
                        pre_cnt_nx = 7'd0;
                    end
                end
                SIGNAL: begin
                    sig_sr_nx  = {Input, sig_sr[22:1]};
                    sig_cnt_nx = sig_cnt + 5'd1;
                    if (sig_cnt == 5'd23) begin
                        sig_cnt_nx  = 5'd0;
                        data_cnt_nx = 15'd0;
                        if (sig_ok) begin
                            sv_nx   = 1'b1;
                            rate_nx = sig_sr[3:0];
                            len_nx  = sig_sr[16:5];
                            if (sig_sr[16:5] == 12'd0) begin
                                fd_nx    = 1'b1;
                                state_nx = HUNT;
                            end else begin
                                state_nx = DATA;
                            end
                        end else begin
                            se_nx    = 1'b1;
                            state_nx = HUNT;
                        end
                    end
                end
                DATA: begin
                    out_nx      = Input;
                    out_vld_nx  = 1'b1;
                    data_cnt_nx = data_cnt + 15'd1;
                    if (data_cnt_nx == {Length, 3'b000}) begin
                        fd_nx       = 1'b1;
                        state_nx    = HUNT;
                        data_cnt_nx = 15'd0;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state       <= HUNT;
            pre_cnt     <= 7'd0;
            pre_exp     <= 1'b0;
            sig_cnt     <= 5'd0;
            sig_sr      <= 23'd0;
            data_cnt    <= 15'd0;
            Output      <= 1'b0;
            OutputValid <= 1'b0;
            Rate        <= 4'h0;
            Length      <= 12'h000;
            SignalValid <= 1'b0;
            SignalError <= 1'b0;
            FrameDone   <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            pre_cnt     <= pre_cnt_nx;
            pre_exp     <= pre_exp_nx;
            sig_cnt     <= sig_cnt_nx;
            sig_sr      <= sig_sr_nx;
            data_cnt    <= data_cnt_nx;
            Output      <= out_nx;
            OutputValid <= out_vld_nx;
            Rate        <= rate_nx;
            Length      <= len_nx;
            SignalValid <= sv_nx;
            SignalError <= se_nx;
            FrameDone   <= fd_nx;
            Busy        <= (state_nx != HUNT);
        end
    end

endmodule

// File: doc/plcp_receiver.md
# plcp_receiver

Serial receive-side counterpart of the 802.11a PLCP transmitter. Hunts for the alternating-bit PLCP preamble, deframes the 24-bit SIGNAL field (RATE, reserved, LENGTH, parity, tail) and forwards exactly LENGTH octets of following payload bits to the downstream descrambler. It sits between the bit-level demodulator output and the receive descrambler.

## Interface

- PREAMBLE_BITS, 96: consecutive alternating bits (1,0,1,0,…; 12 × 8'hAA, MSB first) that constitute a valid preamble.
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- Input  in  1  received serial bit.
- InputValid  in  1  Input is sampled only in cycles where this is high.
- Output  out  1  payload bit, registered.
- OutputValid  out  1  Output holds a payload bit this cycle.
- Rate  out  4  decoded RATE, R1 in bit 0.
- Length  out  12  decoded LENGTH in octets, first-received bit in bit 0.
- SignalValid  out  1  one-cycle pulse: SIGNAL field accepted.
- SignalError  out  1  one-cycle pulse: SIGNAL field rejected.
- FrameDone  out  1  one-cycle pulse: last payload bit presented, or LENGTH = 0 accepted.
- Busy  out  1  high in every state except HUNT.

## Operation

- States: HUNT, PREAMBLE, SIGNAL, DATA. Advance only on cycles with InputValid = 1; otherwise hold all state and counters.
- HUNT: Input = 1 → PREAMBLE, preamble count = 1, expected next bit = 0. Input = 0 → stay.
- PREAMBLE (7-bit counter): bit equal to expected → count+1, toggle expected. Mismatch: bit = 1 → count restarts at 1, stay in PREAMBLE; bit = 0 → HUNT. Count reaching PREAMBLE_BITS → SIGNAL, bit counter = 0.
- SIGNAL (5-bit counter, 24 bits, LSB first): bits 0–3 → Rate[0..3]; bit 4 reserved; bits 5–16 → Length[0..11]; bit 17 even parity over bits 0–16; bits 18–23 tail.
- On the 24th bit evaluate. Accepted → SignalValid pulse; Rate/Length update; go to DATA if Length ≠ 0, else FrameDone pulses together with SignalValid and go to HUNT. Rejected → SignalError pulse, Rate/Length keep previous values, go to HUNT.
- Rejection always when Rate[3] = 0 (not a legal 802.11a rate); further checks per Configuration.
- DATA (15-bit counter, target Length × 8): each valid bit is copied to Output with OutputValid = 1. On the Length×8-th bit FrameDone pulses in the same cycle as that bit's OutputValid; return to HUNT.
- Rate and Length hold their last accepted value until the next accepted SIGNAL.

## Timing

- Reset (Reset = 0 at a rising edge): state HUNT; all counters 0; Output, OutputValid, SignalValid, SignalError, FrameDone, Busy = 0; Rate = 4'h0; Length = 12'h000. Reset overrides all activity, including mid-frame; no FrameDone or SignalError is emitted for an aborted frame.
- Latency: every output is registered; a response to the bit sampled at edge N is visible after edge N.
- Payload: Output/OutputValid lag Input by exactly one cycle; InputValid gaps give OutputValid gaps of the same length.
- SignalValid/SignalError occur one cycle after the 24th SIGNAL bit is sampled; the first payload bit may arrive in the very next valid cycle.
- Busy goes high the cycle after the first preamble 1 is sampled and low the cycle after the transition to HUNT.
- No input back-pressure; downstream must accept one bit per cycle.

## Configuration

- PLCP_RECEIVER_PARITY_CHECK_EN defined: reject SIGNAL if parity bit ≠ XOR of bits 0–16, if reserved bit ≠ 0, or if any tail bit ≠ 0, in addition to the Rate[3] check.
- Undefined: parity, reserved and tail bits are consumed and ignored; only Rate[3] = 0 causes SignalError.

## Test plan

- 96 preamble bits, SIGNAL Rate = 4'b1101, Length = 2, correct parity, zero tail, payload 8'hA5,8'h3C -> SignalValid pulse, Rate = 4'hD, Length = 2, 16 OutputValid bits reproducing the payload in order, FrameDone on the 16th, Busy low afterwards.
- Same frame with InputValid low every other cycle -> identical decoded values; OutputValid pattern shows the same gaps.
- Preamble broken at bit 40 by a repeated 0, then a full 96-bit preamble and valid SIGNAL -> only the second preamble is accepted, exactly one SignalValid.
- SIGNAL with Rate = 4'b0101 -> SignalError, Rate/Length unchanged, no OutputValid; with macro defined, flipped parity bit -> SignalError; without macro, same frame -> SignalValid.
- Length = 0 -> SignalValid and FrameDone in the same cycle, no OutputValid, next edge in HUNT.
- Reset = 0 asserted during the 5th payload bit -> all outputs 0 after that edge, no FrameDone; a fresh frame afterwards decodes correctly.
